mem_bus_master: RTL and testbench

Bus initiator for the system memory map. It accepts single- or multi-word read/write commands from the core and drives the memory controller's address, write-data and write-enable inputs, returning read data through a valid/ready response port. It sits between the core's load/store unit and the memory controller, and is the only driver of the memory controller's inputs. Command ranges are checked against the address map before any bus cycle is issued.

---
 rtl/mem_bus_pkg.sv | 25 ++
 rtl/burst_addr_gen.sv | 34 +++
 rtl/mem_bus_master.sv | 138 +++++++++++++
 tb/tb_mem_bus_master.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared constants and state encoding for the memory bus initiator.
package mem_bus_pkg;

   localparam int unsigned DATA_WIDTH_DEF   = 32;
   localparam int unsigned ADDR_WIDTH_DEF   = 16;
   localparam int unsigned LEN_WIDTH_DEF    = 4;
   localparam int unsigned READ_LATENCY_DEF = 0;
   localparam int unsigned WAIT_WIDTH       = 2;
   localparam int unsigned STATE_WIDTH      = 3;

   // Address map: ROM, I/O window, and last legal word of the map
   localparam logic [15:0] MAP_ROM_LAST = 16'h001F;
   localparam logic [15:0] MAP_IO_LAST  = 16'h002F;
   localparam logic [15:0] MAP_LAST     = 16'h082F;

   typedef logic [STATE_WIDTH-1:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_WRITE     = 3'd1;
   localparam state_t ST_READ_ADDR = 3'd2;
   localparam state_t ST_READ_WAIT = 3'd3;
   localparam state_t ST_READ_RESP = 3'd4;
   localparam state_t ST_DONE      = 3'd5;

endpackage

// File: rtl/burst_addr_gen.sv
// Beat address / remaining-count tracker for one burst.
module burst_addr_gen #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned LEN_WIDTH  = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic                  advance,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [LEN_WIDTH-1:0]  load_len,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last_beat
);

   logic [LEN_WIDTH-1:0] remaining;

   // Load on command accept, step one word per completed beat
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr      <= '0;
         remaining <= '0;
      end else if (load) begin
         addr      <= load_addr;
         remaining <= load_len;
      end else if (advance) begin
         addr      <= addr + ADDR_WIDTH'(1);
         remaining <= remaining - LEN_WIDTH'(1);
      end
   end

   assign last_beat = (remaining == '0);

endmodule

// File: rtl/mem_bus_master.sv
// Burst read/write initiator in front of the memory controller.
module mem_bus_master
   import mem_bus_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int unsigned LEN_WIDTH    = LEN_WIDTH_DEF,
   parameter int unsigned READ_LATENCY = READ_LATENCY_DEF
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int unsigned SUM_WIDTH = ADDR_WIDTH + 1;

   state_t                state;
   state_t                next_state;
   logic                  accept;
   logic                  advance;
   logic                  cap_rdata;
   logic                  range_err;
   logic                  last_beat;
   logic [SUM_WIDTH-1:0]  last_addr;
   logic [WAIT_WIDTH-1:0] wait_cnt;

   // Extra bit on the end address so an overflowing burst is still caught
   assign accept    = cmd_valid && cmd_ready;
   assign last_addr = SUM_WIDTH'(cmd_addr) + SUM_WIDTH'(cmd_len);
   assign range_err = last_addr > SUM_WIDTH'(MAP_LAST);

   // Write strobe follows wr_valid directly so each beat costs one cycle
   assign mem_we    = (state == ST_WRITE) && wr_valid;
   assign mem_wdata = (state == ST_WRITE) ? wr_data : '0;

   burst_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
   ) u_addr_gen (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (accept),
      .advance    (advance),
      .load_addr  (cmd_addr),
      .load_len   (cmd_len),
      .addr       (mem_address),
      .last_beat  (last_beat)
   );

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   // Next-state, beat advance and read-capture decode
   always_comb begin
      next_state = state;
      advance    = 1'b0;
      cap_rdata  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (range_err)      next_state = ST_DONE;
               else if (cmd_write) next_state = ST_WRITE;
               else                next_state = ST_READ_ADDR;
            end
         end
         ST_WRITE: begin
            if (wr_valid) begin
               advance = 1'b1;
               if (last_beat) next_state = ST_DONE;
            end
         end
         ST_READ_ADDR: begin
            if (READ_LATENCY == 0) begin
               cap_rdata  = 1'b1;
               next_state = ST_READ_RESP;
            end else begin
               next_state = ST_READ_WAIT;
            end
         end
         ST_READ_WAIT: begin
            if (wait_cnt == WAIT_WIDTH'(1)) begin
               cap_rdata  = 1'b1;
               next_state = ST_READ_RESP;
            end
         end
         ST_READ_RESP: begin
            if (rd_ready) begin
               advance    = 1'b1;
               next_state = last_beat ? ST_DONE : ST_READ_ADDR;
            end
         end
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // Registered handshake/status outputs, read data and wait counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cmd_ready <= 1'b0;
         wr_ready  <= 1'b0;
         rd_valid  <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         rd_data   <= '0;
         wait_cnt  <= '0;
      end else begin
         cmd_ready <= (next_state == ST_IDLE);
         wr_ready  <= (next_state == ST_WRITE);
         rd_valid  <= (next_state == ST_READ_RESP);
         done      <= (next_state == ST_DONE);
         if (accept)    error   <= range_err;
         if (cap_rdata) rd_data <= mem_rdata;
         if (state == ST_READ_ADDR)      wait_cnt <= WAIT_WIDTH'(READ_LATENCY);
         else if (state == ST_READ_WAIT) wait_cnt <= wait_cnt - WAIT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench: two instances (READ_LATENCY 0 and 2) share command inputs.
module tb_mem_bus_master;

   typedef struct {
      logic [15:0] a;
      logic [31:0] d;
   } wr_exp_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        sel;
   logic        cmd_valid, cmd_write, wr_valid, rd_ready;
   logic [15:0] cmd_addr;
   logic [3:0]  cmd_len;
   logic [31:0] wr_data;
   logic [31:0] tick = '0;

   logic        cmd_ready0, wr_ready0, rd_valid0, done0, error0, mem_we0;
   logic [31:0] rd_data0, mem_wdata0, mem_rdata0;
   logic [15:0] mem_address0;
   logic        cmd_ready2, wr_ready2, rd_valid2, done2, error2, mem_we2;
   logic [31:0] rd_data2, mem_wdata2, mem_rdata2;
   logic [15:0] mem_address2;

   wr_exp_t     exp_wr[$];
   logic [31:0] exp_rd[$];
   logic        exp_done[$];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clock = ~clock;
   always @(posedge clock) tick <= tick + 32'd1;

   function automatic logic [31:0] data_of(input logic [15:0] a);
      return {~a, a};
   endfunction

   assign mem_rdata0 = data_of(mem_address0);
   assign mem_rdata2 = data_of(mem_address2) ^ tick;

   mem_bus_master #(.READ_LATENCY(0)) dut0 (
      .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid & ~sel), .cmd_ready(cmd_ready0),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready0), .rd_data(rd_data0), .rd_valid(rd_valid0),
      .rd_ready(rd_ready), .done(done0), .error(error0), .mem_address(mem_address0),
      .mem_wdata(mem_wdata0), .mem_we(mem_we0), .mem_rdata(mem_rdata0));

   mem_bus_master #(.READ_LATENCY(2)) dut2 (
      .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid & sel), .cmd_ready(cmd_ready2),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready2), .rd_data(rd_data2), .rd_valid(rd_valid2),
      .rd_ready(rd_ready), .done(done2), .error(error2), .mem_address(mem_address2),
      .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_rdata(mem_rdata2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %0h expected nothing", name, act);
   endtask

   // Monitor: pop and compare whenever a DUT presents a write, read beat or done
   always @(negedge clock) begin
      if (reset_n) begin
         if (mem_we0) begin
            if (exp_wr.size() == 0) unexpected("write_unexpected", 32'(mem_address0));
            else begin
               wr_exp_t w;
               w = exp_wr.pop_front();
               check("write_addr", 32'(mem_address0), 32'(w.a));
               check("write_data", mem_wdata0, w.d);
            end
         end
         if (mem_we2) unexpected("write_unexpected_rl2", 32'(mem_address2));
         if (rd_valid0 && rd_ready) begin
            if (exp_rd.size() == 0) unexpected("read_unexpected", rd_data0);
            else check("read_data", rd_data0, exp_rd.pop_front());
         end
         if (rd_valid2 && rd_ready) begin
            if (exp_rd.size() == 0) unexpected("read_unexpected_rl2", rd_data2);
            else check("read_data_rl2", rd_data2, exp_rd.pop_front());
         end
         if (done0 || done2) begin
            if (exp_done.size() == 0) unexpected("done_unexpected", 32'({done0, done2}));
            else check("done_error", 32'(done0 ? error0 : error2), 32'(exp_done.pop_front()));
         end
      end
   end

   task automatic issue(input logic to2, input logic wr, input logic [15:0] a, input logic [3:0] len);
      sel = to2; cmd_write = wr; cmd_addr = a; cmd_len = len; cmd_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (to2 ? cmd_ready2 : cmd_ready0) begin
            @(posedge clock); #1;
            cmd_valid = 1'b0;
            return;
         end
      end
      cmd_valid = 1'b0;
      unexpected("cmd_accept_timeout", 32'(a));
   endtask

   task automatic wait_done(input logic to2);
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (to2 ? done2 : done0) begin
            @(posedge clock); #1;
            return;
         end
      end
      unexpected("done_timeout", 32'(to2));
   endtask

   task automatic wait_rd(input logic to2);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (to2 ? rd_valid2 : rd_valid0) return;
      end
      unexpected("rd_valid_timeout", 32'(to2));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] t0;
      int          k;
      reset_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_len = '0; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clock);
      check("rst_flags", 32'({cmd_ready0, wr_ready0, rd_valid0, done0, error0, mem_we0}), 32'd0);
      check("rst_addr", 32'(mem_address0), 32'd0);
      check("rst_rdata", rd_data0, 32'd0);
      check("rst_wdata", mem_wdata0, 32'd0);
      reset_n = 1'b1;
      @(posedge clock); #1;
      check("cmd_ready_after_reset", 32'(cmd_ready0), 32'd1);

      // Single write
      exp_wr.push_back('{16'h0030, 32'hDEADBEEF});
      exp_done.push_back(1'b0);
      issue(1'b0, 1'b1, 16'h0030, 4'd0);
      wr_valid = 1'b1; wr_data = 32'hDEADBEEF;
      @(negedge clock);
      check("single_we", 32'(mem_we0), 32'd1);
      @(posedge clock); #1;
      wr_valid = 1'b0;
      @(negedge clock);
      check("single_done", 32'(done0), 32'd1);
      check("single_cmd_ready_in_done", 32'(cmd_ready0), 32'd0);
      @(negedge clock);
      check("cmd_ready_after_done", 32'(cmd_ready0), 32'd1);
      check("done_one_cycle", 32'(done0), 32'd0);
      @(posedge clock); #1;

      // 4-beat ROM read with a 3-cycle stall on the second beat
      for (int i = 0; i < 4; i++) exp_rd.push_back(data_of(16'(i)));
      exp_done.push_back(1'b0);
      rd_ready = 1'b1;
      issue(1'b0, 1'b0, 16'h0000, 4'd3);
      wait_rd(1'b0);
      @(posedge clock); #1;
      rd_ready = 1'b0;
      wait_rd(1'b0);
      for (int s = 0; s < 3; s++) begin
         if (s != 0) @(negedge clock);
         check("stall_valid", 32'(rd_valid0), 32'd1);
         check("stall_addr", 32'(mem_address0), 32'h0001);
         check("stall_data", rd_data0, data_of(16'h0001));
      end
      @(posedge clock); #1;
      rd_ready = 1'b1;
      wait_done(1'b0);

      // Range error (last = 0830) then the last legal word
      exp_done.push_back(1'b1);
      wr_valid = 1'b1;
      issue(1'b0, 1'b1, 16'h082C, 4'd4);
      @(negedge clock);
      check("range_done", 32'(done0), 32'd1);
      check("range_error", 32'(error0), 32'd1);
      @(posedge clock); #1;
      wr_valid = 1'b0;
      exp_rd.push_back(data_of(16'h082F));
      exp_done.push_back(1'b0);
      issue(1'b0, 1'b0, 16'h082F, 4'd0);
      wait_done(1'b0);

      // Write with gaps: wr_valid 1,0,1,0,1
      for (int i = 0; i < 3; i++) exp_wr.push_back('{16'h0200 + 16'(i), 32'h1111_0000 + 32'(i)});
      exp_done.push_back(1'b0);
      issue(1'b0, 1'b1, 16'h0200, 4'd2);
      k = 0;
      for (int i = 0; i < 5; i++) begin
         wr_valid = (i % 2 == 0);
         wr_data  = 32'h1111_0000 + 32'(k);
         @(negedge clock);
         check("gap_we", 32'(mem_we0), 32'(i % 2 == 0));
         @(posedge clock); #1;
         if (i % 2 == 0) k++;
      end
      wr_valid = 1'b0;
      wait_done(1'b0);

      // READ_LATENCY=2 read from the I/O window
      issue(1'b1, 1'b0, 16'h0020, 4'd0);
      t0 = tick;
      exp_rd.push_back(data_of(16'h0020) ^ (t0 + 32'd2));
      exp_done.push_back(1'b0);
      @(negedge clock);
      check("rl2_addr", 32'(mem_address2), 32'h0020);
      check("rl2_not_valid", 32'(rd_valid2), 32'd0);
      wait_rd(1'b1);
      check("rl2_latency", tick, t0 + 32'd3);
      wait_done(1'b1);
      sel = 1'b0;

      // Reset in the middle of an 8-beat write
      for (int i = 0; i < 3; i++) exp_wr.push_back('{16'h0100 + 16'(i), 32'hC0DE_0000 + 32'(i)});
      issue(1'b0, 1'b1, 16'h0100, 4'd7);
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = 32'hC0DE_0000 + 32'(i);
         @(posedge clock); #1;
      end
      reset_n = 1'b0;
      #1;
      check("midrst_we", 32'(mem_we0), 32'd0);
      check("midrst_flags", 32'({cmd_ready0, wr_ready0, rd_valid0, done0, error0}), 32'd0);
      check("midrst_addr", 32'(mem_address0), 32'd0);
      check("midrst_wdata", mem_wdata0, 32'd0);
      wr_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      check("midrst_cmd_ready", 32'(cmd_ready0), 32'd1);
      exp_wr.push_back('{16'h0050, 32'hCAFEF00D});
      exp_done.push_back(1'b0);
      issue(1'b0, 1'b1, 16'h0050, 4'd0);
      wr_valid = 1'b1; wr_data = 32'hCAFEF00D;
      @(posedge clock); #1;
      wr_valid = 1'b0;
      wait_done(1'b0);

      repeat (2) @(negedge clock);
      check("scoreboard_drained", 32'(exp_wr.size() + exp_rd.size() + exp_done.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
